// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: accelerator count, strip constants, sequencer state encoding
// and the write-mask helper.
package sobel_pkg;

  localparam int NUM_SOBEL_ACCELERATORS = 8;
  localparam int SOBEL_STRIP_WIDTH      = NUM_SOBEL_ACCELERATORS;
  localparam logic [NUM_SOBEL_ACCELERATORS-1:0] SOBEL_MASK_ALL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_SHIFT,
    S_COMPUTE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } sobel_state_e;

  // One enable bit per accelerator whose output column still lies inside the image.
  function automatic logic [NUM_SOBEL_ACCELERATORS-1:0] sobel_strip_mask(input logic [31:0] remaining);
    logic [NUM_SOBEL_ACCELERATORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SOBEL_ACCELERATORS; i++) begin
      m[i] = SOBEL_MASK_ALL[i] & (32'(i) < remaining);
    end
    return m;
  endfunction

endpackage

// File: rtl/sobel_sequencer_if.sv
// Memory read, row-shift and Sobel write-back handshakes between the sequencer and its datapath.
interface sobel_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  import sobel_pkg::*;

  logic                              sctl2mem_rd_en;
  logic [ADDR_WIDTH-1:0]             sctl2mem_rd_addr;
  logic                              mem2sctl_rd_gnt;
  logic                              mem2sctl_rd_valid;
  logic                              sctl2srow_shift;
  logic                              sctl2swt_wr_en;
  logic [ADDR_WIDTH-1:0]             sctl2swt_wr_addr;
  logic [NUM_SOBEL_ACCELERATORS-1:0] sctl2swt_wr_mask;
  logic                              swt2sctl_wr_ack;

  modport master (
    output sctl2mem_rd_en, sctl2mem_rd_addr, sctl2srow_shift,
           sctl2swt_wr_en, sctl2swt_wr_addr, sctl2swt_wr_mask,
    input  mem2sctl_rd_gnt, mem2sctl_rd_valid, swt2sctl_wr_ack
  );

  modport slave (
    input  sctl2mem_rd_en, sctl2mem_rd_addr, sctl2srow_shift,
           sctl2swt_wr_en, sctl2swt_wr_addr, sctl2swt_wr_mask,
    output mem2sctl_rd_gnt, mem2sctl_rd_valid, swt2sctl_wr_ack
  );

endinterface

// File: rtl/sobel_addr_gen.sv
// Row/column counters for the strip walk; keeps running read/write pointers so no multiplier
// is needed, and derives the write mask for the current strip.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              load,
  input  logic                              advance,
  input  logic [DIM_WIDTH-1:0]              img_width,
  input  logic [DIM_WIDTH-1:0]              img_height,
  input  logic [ADDR_WIDTH-1:0]             ibase,
  input  logic [ADDR_WIDTH-1:0]             obase,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [NUM_SOBEL_ACCELERATORS-1:0] wr_mask,
  output logic                              row_ge2,
  output logic                              last_row,
  output logic                              last_strip
);

  localparam int CW = DIM_WIDTH + 1;

  logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0] ibase_q, ibase_d, obase_q, obase_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         col_ext, limit, col_step;

  // One extra bit so col+N cannot overflow when comparing against W-2.
  assign col_ext    = CW'(col_q);
  assign limit      = CW'(w_q) - CW'(2);
  assign col_step   = col_ext + CW'(SOBEL_STRIP_WIDTH);
  assign last_strip = (col_step >= limit);
  assign last_row   = (row_q == h_q - DIM_WIDTH'(1));
  assign row_ge2    = (row_q >= DIM_WIDTH'(2));
  assign wr_mask    = sobel_strip_mask(32'(limit - col_ext));
  assign rd_addr    = rd_ptr_q;
  assign wr_addr    = wr_ptr_q;

  always_comb begin
    w_d      = w_q;
    h_d      = h_q;
    ibase_d  = ibase_q;
    obase_d  = obase_q;
    row_d    = row_q;
    col_d    = col_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (load) begin
      w_d      = img_width;
      h_d      = img_height;
      ibase_d  = ibase;
      obase_d  = obase;
      row_d    = '0;
      col_d    = '0;
      rd_ptr_d = ibase;
      wr_ptr_d = obase;
    end else if (advance) begin
      if (last_row) begin
        row_d    = '0;
        col_d    = DIM_WIDTH'(col_step);
        rd_ptr_d = ibase_q + ADDR_WIDTH'(col_step);
        wr_ptr_d = obase_q + ADDR_WIDTH'(col_step);
      end else begin
        row_d    = row_q + DIM_WIDTH'(1);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(w_q);
        // The write pointer trails the read pointer by two rows.
        if (row_ge2) begin
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(w_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q      <= '0;
      h_q      <= '0;
      ibase_q  <= '0;
      obase_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      w_q      <= w_d;
      h_q      <= h_d;
      ibase_q  <= ibase_d;
      obase_q  <= obase_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/sobel_sequencer.sv
// Sobel strip sequencer FSM: one read per row, one write per output row, strip by strip.
// Define SOBEL_PERF_CNT_EN to add the cycle_cnt busy-cycle counter output.
module sobel_sequencer
  import sobel_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [DIM_WIDTH-1:0]  img_width,
  input  logic [DIM_WIDTH-1:0]  img_height,
  input  logic [ADDR_WIDTH-1:0] ibase,
  input  logic [ADDR_WIDTH-1:0] obase,
  sobel_sequencer_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SOBEL_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt
`endif
);

  sobel_state_e state_q, state_d;
  logic err_q, err_d;
  logic go_ok, dims_ok, start, advance;
  logic row_ge2, last_row, last_strip;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [NUM_SOBEL_ACCELERATORS-1:0] wr_mask;

  assign go_ok   = go && (state_q == S_IDLE);
  assign dims_ok = (img_width >= DIM_WIDTH'(3)) && (img_height >= DIM_WIDTH'(3));
  assign start   = go_ok && dims_ok;

  sobel_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (start),
    .advance    (advance),
    .img_width  (img_width),
    .img_height (img_height),
    .ibase      (ibase),
    .obase      (obase),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .row_ge2    (row_ge2),
    .last_row   (last_row),
    .last_strip (last_strip)
  );

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    // A rejected go reports err+done next cycle without ever leaving IDLE.
    err_d   = go_ok && !dims_ok;
    case (state_q)
      S_IDLE:      if (start) state_d = S_READ;
      S_READ:      if (bus.mem2sctl_rd_gnt) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (bus.mem2sctl_rd_valid) state_d = S_SHIFT;
      S_SHIFT:     state_d = row_ge2 ? S_COMPUTE : S_NEXT;
      S_COMPUTE:   state_d = S_WRITE;
      S_WRITE:     if (bus.swt2sctl_wr_ack) state_d = S_NEXT;
      S_NEXT: begin
        if (last_row && last_strip) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.sctl2mem_rd_en   = (state_q == S_READ);
  assign bus.sctl2mem_rd_addr = bus.sctl2mem_rd_en ? rd_addr : '0;
  assign bus.sctl2srow_shift  = (state_q == S_SHIFT);
  assign bus.sctl2swt_wr_en   = (state_q == S_WRITE);
  assign bus.sctl2swt_wr_addr = bus.sctl2swt_wr_en ? wr_addr : '0;
  assign bus.sctl2swt_wr_mask = bus.sctl2swt_wr_en ? wr_mask : '0;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) || err_q;
  assign err  = err_q;

`ifdef SOBEL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (go_ok) begin
      cycle_cnt_d = '0;
    end else if (busy && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
